// File: rtl/onehot_sweep_seq.sv
// One-hot sweep sequencer: walks a single set bit across N lines, optionally
// returning to a home slot between positions, with trailing blank slots.
module onehot_sweep_seq #(
    parameter int N = 8,
    parameter int HOLD = 1,
    parameter int INTERLEAVE = 1,
    parameter int BLANKS = 2,
    localparam int ACT = (INTERLEAVE != 0) ? 2 * (N - 1) : N,
    localparam int L = ACT + BLANKS,
    localparam int SW = (L > 1) ? $clog2(L) : 1,
    localparam int PW = (HOLD > 1) ? $clog2(HOLD) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [1:0]    mode,
    input  logic          oneshot,
    input  logic          start,
    output logic [N-1:0]  count,
    output logic [SW-1:0] slot,
    output logic          busy,
    output logic          frame_done
);

    typedef enum logic {RUN, IDLE} state_t;

    state_t        state, state_n;
    logic [SW-1:0] slot_n;
    logic [PW-1:0] presc, presc_n;
    logic          down, down_n;
    logic          fd, fd_n;
    logic          dir_sel;
    logic          hit;
    int            idx;
    int            s;

    // Direction for the frame about to start; bounce flips the last one.
    always_comb begin
        dir_sel = 1'b0;
        unique case (mode)
            2'b01:   dir_sel = 1'b1;
            2'b10:   dir_sel = ~down;
            default: dir_sel = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        slot_n  = slot;
        presc_n = presc;
        down_n  = down;
        fd_n    = 1'b0;
        unique case (state)
            RUN: begin
                if (en) begin
                    if (presc == PW'(HOLD - 1)) begin
                        presc_n = '0;
                        if (slot == SW'(L - 1)) begin
                            fd_n   = 1'b1;
                            slot_n = '0;
                            if (oneshot) state_n = IDLE;
                            else         down_n  = dir_sel;
                        end else begin
                            slot_n = slot + 1'b1;
                        end
                    end else begin
                        presc_n = presc + 1'b1;
                    end
                end
            end
            IDLE: begin
                slot_n  = '0;
                presc_n = '0;
                if (start) begin
                    state_n = RUN;
                    down_n  = dir_sel;
                end
            end
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            slot  <= '0;
            presc <= '0;
            down  <= 1'b0;
            fd    <= 1'b0;
        end else begin
            state <= state_n;
            slot  <= slot_n;
            presc <= presc_n;
            down  <= down_n;
            fd    <= fd_n;
        end
    end

    // Pattern is a pure decode of slot and direction: no extra latency.
    always_comb begin
        hit   = 1'b0;
        idx   = 0;
        s     = int'(slot);
        count = '0;
        if (state == RUN && s < ACT) begin
            hit = 1'b1;
            if (INTERLEAVE != 0) begin
                if (s % 2 == 0) idx = 0;
                else if (down)  idx = N - 1 - s / 2;
                else            idx = s / 2 + 1;
            end else begin
                idx = down ? N - 1 - s : s;
            end
        end
        for (int i = 0; i < N; i++)
            count[i] = hit && (idx == i);
    end

    assign busy       = (state == RUN);
    assign frame_done = fd;

endmodule

// File: tb/tb_onehot_sweep_seq.sv
// Directed bench for onehot_sweep_seq: walk, bounce, hold/enable,
// one-shot and mid-frame reset scenarios with hand-written vectors.
module tb_onehot_sweep_seq;

    logic       clk = 1'b0;
    logic       reset, en, oneshot, start;
    logic [1:0] mode;
    logic [7:0] count;
    logic [3:0] slot;
    logic       busy, frame_done;

    logic       reset1, en1;
    logic [1:0] mode1;
    logic       oneshot1, start1;
    logic [7:0] count1;
    logic [3:0] slot1;
    logic       busy1, fd1;

    int checks = 0;
    int errors = 0;

    logic [7:0] up_t [16] = '{8'h01, 8'h02, 8'h01, 8'h04, 8'h01, 8'h08,
                              8'h01, 8'h10, 8'h01, 8'h20, 8'h01, 8'h40,
                              8'h01, 8'h80, 8'h00, 8'h00};
    logic [7:0] dn_t [16] = '{8'h01, 8'h80, 8'h01, 8'h40, 8'h01, 8'h20,
                              8'h01, 8'h10, 8'h01, 8'h08, 8'h01, 8'h04,
                              8'h01, 8'h02, 8'h00, 8'h00};

    always #5 clk = ~clk;

    onehot_sweep_seq u0 (
        .clk(clk), .reset(reset), .en(en), .mode(mode),
        .oneshot(oneshot), .start(start), .count(count),
        .slot(slot), .busy(busy), .frame_done(frame_done)
    );

    onehot_sweep_seq #(.HOLD(3)) u1 (
        .clk(clk), .reset(reset1), .en(en1), .mode(mode1),
        .oneshot(oneshot1), .start(start1), .count(count1),
        .slot(slot1), .busy(busy1), .frame_done(fd1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input logic dn, input logic fd0, input int len,
                             input int chg_at, input logic [1:0] nm,
                             input int st_at);
        for (int i = 0; i < len; i++) begin
            if (i == chg_at) mode = nm;
            start = (i == st_at);
            chk("count", 32'(count), 32'(dn ? dn_t[i] : up_t[i]));
            chk("slot", 32'(slot), i);
            chk("frame_done", 32'(frame_done), 32'((i == 0) ? fd0 : 1'b0));
            chk("busy", 32'(busy), 1);
            step();
        end
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; mode = 2'b00; oneshot = 1'b0; start = 1'b0;
        reset1 = 1'b1; en1 = 1'b1; mode1 = 2'b00;
        oneshot1 = 1'b0; start1 = 1'b0;
        step();
        reset = 1'b0;
        reset1 = 1'b0;

        // HOLD=3: en low for cycles 10..13 (prescaler=1 of slot 3)
        for (int c = 0; c < 22; c++) begin
            int es;
            en1 = !(c >= 10 && c <= 13);
            if (c < 9)       es = c / 3;
            else if (c < 16) es = 3;
            else if (c < 19) es = 4;
            else             es = 5;
            chk("hold_slot", 32'(slot1), es);
            chk("hold_count", 32'(count1), 32'(up_t[es]));
            step();
        end

        // Reset state and walk up
        do_reset();
        chk("rst_count", 32'(count), 32'h01);
        chk("rst_slot", 32'(slot), 0);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_fd", 32'(frame_done), 0);
        run_frame(1'b0, 1'b0, 16, -1, 2'b00, -1);
        run_frame(1'b0, 1'b1, 16, -1, 2'b00, -1);
        run_frame(1'b0, 1'b1, 15, -1, 2'b00, -1);
        // en low across the completing edge delays wrap and frame_done
        en = 1'b0;
        step();
        step();
        chk("stall_slot", 32'(slot), 15);
        chk("stall_fd", 32'(frame_done), 0);
        chk("stall_count", 32'(count), 0);
        en = 1'b1;
        step();
        chk("wrap_slot", 32'(slot), 0);
        chk("wrap_fd", 32'(frame_done), 1);
        chk("wrap_count", 32'(count), 32'h01);

        // Bounce, then mode changes mid-frame taking effect next frame
        mode = 2'b10;
        do_reset();
        run_frame(1'b0, 1'b0, 16, -1, 2'b00, -1);
        run_frame(1'b1, 1'b1, 16, 5, 2'b00, -1);
        run_frame(1'b0, 1'b1, 16, 5, 2'b01, -1);
        run_frame(1'b1, 1'b1, 16, -1, 2'b00, -1);
        run_frame(1'b1, 1'b1, 16, -1, 2'b00, -1);

        // Reset at slot 9 of bounce frame 2
        mode = 2'b10;
        do_reset();
        run_frame(1'b0, 1'b0, 16, -1, 2'b00, -1);
        run_frame(1'b1, 1'b1, 9, -1, 2'b00, -1);
        start = 1'b1;
        do_reset();
        start = 1'b0;
        chk("mrst_slot", 32'(slot), 0);
        chk("mrst_count", 32'(count), 32'h01);
        chk("mrst_fd", 32'(frame_done), 0);
        run_frame(1'b0, 1'b0, 16, -1, 2'b00, -1);
        run_frame(1'b1, 1'b1, 16, -1, 2'b00, -1);

        // One-shot: start ignored in RUN, accepted in IDLE even with en=0
        mode = 2'b00;
        oneshot = 1'b1;
        do_reset();
        run_frame(1'b0, 1'b0, 16, -1, 2'b00, 6);
        chk("os_count", 32'(count), 0);
        chk("os_busy", 32'(busy), 0);
        chk("os_fd", 32'(frame_done), 1);
        chk("os_slot", 32'(slot), 0);
        step();
        chk("idle_fd", 32'(frame_done), 0);
        chk("idle_busy", 32'(busy), 0);
        step();
        en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("go_count", 32'(count), 32'h01);
        chk("go_busy", 32'(busy), 1);
        chk("go_slot", 32'(slot), 0);
        step();
        chk("frz_count", 32'(count), 32'h01);
        chk("frz_slot", 32'(slot), 0);
        en = 1'b1;
        run_frame(1'b0, 1'b0, 16, -1, 2'b00, -1);
        chk("os2_busy", 32'(busy), 0);
        chk("os2_fd", 32'(frame_done), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
